gb_host_bridge: RTL



---
 rtl/gb_host_pkg.sv | 37 +++
 rtl/gb_host_lat_cnt.sv | 30 +++
 rtl/gb_host_bridge.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gb_host_pkg.sv
// gb_host_pkg: shared types and constants for the ghostbus host bridge.
// Consumers: gb_host_bridge (top) and gb_host_lat_cnt (read latency counter).
package gb_host_pkg;

  // Default bus geometry and read latency
  localparam int GB_AW_DEF     = 24;
  localparam int GB_DW_DEF     = 32;
  localparam int GB_RD_LAT_DEF = 1;

  // Largest read latency the 4-bit counter can express
  localparam int RD_LAT_MAX    = 15;
  localparam int LAT_CNT_W     = 4;

  // Width of the extra-beat count carried with a read command
  localparam int LEN_W         = 8;

  // Bridge sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RSP      = 3'd4
  } gb_state_e;

  // Saturating conversion of a latency parameter into counter width
  function automatic logic [LAT_CNT_W-1:0] lat_to_cnt(input int lat);
    if (lat > RD_LAT_MAX) begin
      return LAT_CNT_W'(RD_LAT_MAX);
    end
    if (lat < 0) begin
      return '0;
    end
    return LAT_CNT_W'(lat);
  endfunction

endpackage

// File: rtl/gb_host_lat_cnt.sv
// gb_host_lat_cnt: 4-bit loadable down-counter for the ghostbus read latency.
// o_done pulses for one cycle when the count passes through 1, which is the
// cycle on which the read data on the bus must be captured. Loading 0 never
// produces a strobe; the bridge handles zero latency without the counter.
module gb_host_lat_cnt
  import gb_host_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [LAT_CNT_W-1:0] i_load_val,
  output logic                 o_done
);

  logic [LAT_CNT_W-1:0] r_cnt;

  // Load on request, otherwise count down to zero and rest there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == LAT_CNT_W'(1));

endmodule

// File: rtl/gb_host_bridge.sv
// gb_host_bridge: command-stream host at the top of the ghostbus hierarchy.
// Turns valid/ready commands (single writes, single or burst reads) into
// gb_we/gb_re strobes, waits RD_LAT cycles for read data and returns it on a
// valid/ready response stream. Every output is registered and resets to 0.
// Optional feature macro: GB_HOST_AUTOINC_EN adds the cmd_len port so a read
// performs cmd_len+1 beats at consecutive (wrapping) addresses. Without it
// every read is a single beat and rsp_last accompanies every response.
module gb_host_bridge
  import gb_host_pkg::*;
#(
  parameter int AW     = GB_AW_DEF,
  parameter int DW     = GB_DW_DEF,
  parameter int RD_LAT = GB_RD_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [DW-1:0]    cmd_wdata,
`ifdef GB_HOST_AUTOINC_EN
  input  logic [LEN_W-1:0] cmd_len,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_last,
  output logic [AW-1:0]    gb_addr,
  output logic [DW-1:0]    gb_wdata,
  output logic             gb_we,
  output logic             gb_re,
  input  logic [DW-1:0]    gb_rdata,
  output logic             busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_to_cnt(RD_LAT);
  localparam bit                   LAT_ZERO = (RD_LAT <= 0);

  gb_state_e         r_state;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_gb_we;
  logic              r_gb_re;
  logic [AW-1:0]     r_gb_addr;
  logic [DW-1:0]     r_gb_wdata;
  logic              r_rsp_valid;
  logic [DW-1:0]     r_rsp_rdata;
  logic              r_rsp_last;
  logic [LEN_W-1:0]  r_beats;

  logic              w_accept;
  logic              w_lat_load;
  logic              w_lat_done;
  logic [LEN_W-1:0]  w_cmd_len;

`ifdef GB_HOST_AUTOINC_EN
  assign w_cmd_len = cmd_len;
`else
  assign w_cmd_len = '0;
`endif

  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_lat_load = (r_state == RD_ISSUE);

  gb_host_lat_cnt u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_lat_load),
    .i_load_val (LAT_LOAD),
    .o_done     (w_lat_done)
  );

  // Command sequencing FSM; strobes default low and pulse for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_gb_we     <= 1'b0;
      r_gb_re     <= 1'b0;
      r_gb_addr   <= '0;
      r_gb_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_last  <= 1'b0;
      r_beats     <= '0;
    end else begin
      r_gb_we <= 1'b0;
      r_gb_re <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_gb_addr   <= cmd_addr;
            if (cmd_we) begin
              r_gb_wdata <= cmd_wdata;
              r_gb_we    <= 1'b1;
              r_state    <= WR;
            end else begin
              r_gb_re <= 1'b1;
              r_beats <= w_cmd_len;
              r_state <= RD_ISSUE;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        WR: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end

        RD_ISSUE: begin
          if (LAT_ZERO) begin
            r_rsp_rdata <= gb_rdata;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= (r_beats == '0);
            r_state     <= RSP;
          end else begin
            r_state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (w_lat_done) begin
            r_rsp_rdata <= gb_rdata;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= (r_beats == '0);
            r_state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            if (r_beats != '0) begin
              r_beats   <= r_beats - 1'b1;
              r_gb_addr <= r_gb_addr + AW'(1);
              r_gb_re   <= 1'b1;
              r_state   <= RD_ISSUE;
            end else begin
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end

        default: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_last  <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign gb_we     = r_gb_we;
  assign gb_re     = r_gb_re;
  assign gb_addr   = r_gb_addr;
  assign gb_wdata  = r_gb_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_last  = r_rsp_last;

endmodule
